// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
//   state_e        : arbiter FSM state (IDLE / OWN)
//   onehot_to_idx  : index of the set bit in a one-hot vector of up to 16 bits
package rr_burst_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  // Input must be one-hot or zero; OR-ing the indices of set bits is then exact.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_burst_arbiter_pick.sv
// rr_pick: combinational round-robin winner selection.
//   req_i  [N-1:0]  request vector
//   ptr_i  [PW-1:0] last owner; search starts at ptr_i+1 and wraps, so the
//                   port at ptr_i itself has lowest priority
//   win_o  [N-1:0]  one-hot winner (zero when no request)
//   vld_o           at least one request present
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic          vld_o
);

  logic [N-1:0]   above;
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] first;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      above[i] = (i > int'(ptr_i));
    end
  end

  // Double-width vector: low half holds requests strictly above the pointer,
  // high half holds all requests (the wrapped-around search). Isolating the
  // lowest set bit of the whole vector yields the round-robin winner.
  assign dbl   = {req_i, req_i & above};
  assign first = dbl & (~dbl + (2*N)'(1));
  assign win_o = first[N-1:0] | first[2*N-1:N];
  assign vld_o = |req_i;

endmodule

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: round-robin arbiter with burst locking.
// A winner keeps its registered one-hot grant until it drops its request,
// pulses done_i, or (with RR_BURST_LIMIT_EN defined) reaches MAX_BURST grant
// cycles. On release the next owner is granted in the same cycle decision,
// with the old owner at lowest priority, so there is no idle bubble.
// Optional macro: RR_BURST_LIMIT_EN (enables the MAX_BURST hand-over).
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   req_i        per-port request levels
//   done_i       owner's last beat this cycle (ignored when idle)
//   gnt_o        one-hot registered grant
//   gnt_id_o     owner index, valid while busy_o
//   busy_o       resource owned
//   burst_cnt_o  grant cycles consumed by current owner, saturating
module rr_burst_arbiter
  import rr_burst_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_BURST = 8,
  localparam int IDW = $clog2(NUM_PORTS),
  localparam int CW  = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 done_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDW-1:0]       gnt_id_o,
  output logic                 busy_o,
  output logic [CW-1:0]        burst_cnt_o
);

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [NUM_PORTS-1:0] win;
  logic                 pick_vld;
  logic [IDW-1:0]       pick_ptr;
  logic [IDW-1:0]       win_idx;
  logic [15:0]          win16;
  logic                 lim_hit;
  logic                 rel;

  // While owning, the pick is only consumed on release, where the pointer
  // becomes the owner; feeding the owner directly avoids a cycle of delay.
  assign pick_ptr = (state_q == ST_OWN) ? id_q : ptr_q;

  rr_pick #(.N(NUM_PORTS), .PW(IDW)) u_pick (
    .req_i (req_i),
    .ptr_i (pick_ptr),
    .win_o (win),
    .vld_o (pick_vld)
  );

  always_comb begin
    win16 = '0;
    win16[NUM_PORTS-1:0] = win;
  end
  assign win_idx = IDW'(onehot_to_idx(win16));

`ifdef RR_BURST_LIMIT_EN
  assign lim_hit = (cnt_q == CW'(MAX_BURST));
`else
  assign lim_hit = 1'b0;
`endif

  // A simultaneous request drop and done collapse into this one release.
  assign rel = !req_i[id_q] || done_i || lim_hit;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d   = win;
          id_d    = win_idx;
          cnt_d   = CW'(1);
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!rel) begin
          if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        end else begin
          ptr_d = id_q;
          if (pick_vld) begin
            gnt_d = win;
            id_d  = win_idx;
            cnt_d = CW'(1);
          end else begin
            gnt_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= IDW'(NUM_PORTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = id_q;
  assign busy_o      = |gnt_q;
  assign burst_cnt_o = cnt_q;

endmodule
